// File: rtl/bf16_div_arbiter.sv
// bf16_div_arbiter: round-robin sharing of one multi-cycle bf16 divider among NREQ requesters,
// one operation in flight, id-tagged responses and a watchdog abort for a hung divider.
module bf16_div_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_vld,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_res,
    output logic                 rsp_exc,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [15:0]          div_a,
    output logic [15:0]          div_b,
    output logic                 div_en,
    input  logic [15:0]          div_res,
    input  logic                 div_exc,
    input  logic                 div_res_vld
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t          state;
    logic [IDW-1:0]  rr_ptr, cur_id, gnt_id;
    logic [7:0]      cnt;
    logic [NREQ-1:0] gnt;
    logic            found;
    int              idx;
    assign req_rdy = gnt;
    assign rsp_vld = state == RESP;
    assign rsp_id  = cur_id;
    assign busy    = state != IDLE;
    assign div_en  = state == ISSUE || state == WAIT;
    // Search starts just above the last winner so every holder is served within NREQ operations.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (state == IDLE && !rst)
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!found && req_vld[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                end
            end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IDW'(NREQ - 1);
            cur_id      <= '0;
            cnt         <= '0;
            div_a       <= '0;
            div_b       <= '0;
            rsp_res     <= '0;
            rsp_exc     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    div_a  <= req_a[16*int'(gnt_id) +: 16];
                    div_b  <= req_b[16*int'(gnt_id) +: 16];
                    cur_id <= gnt_id;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A result arriving on the expiry cycle still beats the watchdog.
                    if (div_res_vld) begin
                        rsp_res     <= div_res;
                        rsp_exc     <= div_exc;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        rsp_res     <= 16'h0000;
                        rsp_exc     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= cur_id;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
